vm2002_change_dispenser: RTL and testbench

- Sequences the coin ejector that returns change after a vend or a cancel.
- Takes a change amount in cents and tracks the stock of each coin tube.
- Issues one coin per ready/valid handshake to the ejector, choosing the largest stocked coin first.
- Sits between the main vending FSM, which supplies the change amount, and the coin ejector mechanism. It also counts inserted coins into the tubes.

---
 rtl/vm2002_change_dispenser_if.sv | 52 +++++
 rtl/vm2002_change_dispenser.sv | 193 +++++++++++++++++++
 tb/tb_vm2002_change_dispenser.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/vm2002_change_dispenser_if.sv
// -----------------------------------------------------------------------------
// vm2002_change_dispenser_if
//
// Bundles every non-clock signal of the change dispenser. There are three
// groups:
//   - change request and result: change_req, change_amount, change_busy,
//     change_done, change_short, remaining
//   - ejector handshake: coin_valid, coin_type, coin_ready
//   - tube bookkeeping: deposit_valid, deposit_coin, nickel_cnt, dime_cnt,
//     quarter_cnt
//
// Modports:
//   master : the surroundings. This is the vending FSM, the ejector and the
//            coin router. It drives requests, coin_ready and deposits.
//   slave  : the dispenser itself.
// -----------------------------------------------------------------------------
interface vm2002_change_dispenser_if #(
   parameter int AMOUNT_W = 8,
   parameter int TUBE_W   = 4
);
   // change request / result
   logic                change_req;
   logic [AMOUNT_W-1:0] change_amount;
   logic                change_busy;
   logic                change_done;
   logic                change_short;
   logic [AMOUNT_W-1:0] remaining;

   // ejector handshake
   logic                coin_valid;
   logic [1:0]          coin_type;
   logic                coin_ready;

   // tube bookkeeping
   logic                deposit_valid;
   logic [1:0]          deposit_coin;
   logic [TUBE_W-1:0]   nickel_cnt;
   logic [TUBE_W-1:0]   dime_cnt;
   logic [TUBE_W-1:0]   quarter_cnt;

   modport master (
      output change_req, change_amount, coin_ready, deposit_valid, deposit_coin,
      input  change_busy, change_done, change_short, remaining,
             coin_valid, coin_type, nickel_cnt, dime_cnt, quarter_cnt
   );

   modport slave (
      input  change_req, change_amount, coin_ready, deposit_valid, deposit_coin,
      output change_busy, change_done, change_short, remaining,
             coin_valid, coin_type, nickel_cnt, dime_cnt, quarter_cnt
   );
endinterface

// File: rtl/vm2002_change_dispenser.sv
// -----------------------------------------------------------------------------
// vm2002_change_dispenser
//
// Pays out change after a vend or a cancel. It also keeps count of the coins
// in each tube.
//
// The owed amount is captured when change_req arrives. The block then loops
// through SELECT and EJECT. Each SELECT picks the largest coin that is both
// in stock and no larger than the balance. Each EJECT offers that coin to the
// ejector with a valid/ready handshake. When nothing more can be paid, DONE
// pulses change_done for one cycle. change_short flags any unpaid residue,
// and that residue is left in remaining.
//
// Coins routed into the tubes (deposit_valid/deposit_coin) are counted in
// every state. Each tube count saturates at its maximum value.
//
// Ports:
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : vm2002_change_dispenser_if.slave, which carries
//            - change_req / change_amount  (in)  start request and amount
//            - change_busy                 (out) high outside IDLE
//            - coin_valid / coin_type      (out) coin offered to the ejector
//            - coin_ready                  (in)  ejector accepts the coin
//            - change_done / change_short  (out) end pulse and shortfall flag
//            - remaining                   (out) balance still owed
//            - deposit_valid / deposit_coin(in)  coin routed into a tube
//            - nickel/dime/quarter_cnt     (out) tube stock
// -----------------------------------------------------------------------------
module vm2002_change_dispenser #(
   parameter int AMOUNT_W   = 8,
   parameter int TUBE_W     = 4,
   parameter int TUBE_RESET = 8
) (
   input  logic                        clk,
   input  logic                        rst_n,
   vm2002_change_dispenser_if.slave    bus
);

   typedef enum logic [1:0] {
      COIN_NONE    = 2'd0,
      COIN_NICKEL  = 2'd1,
      COIN_DIME    = 2'd2,
      COIN_QUARTER = 2'd3
   } coins_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SELECT = 2'd1,
      EJECT  = 2'd2,
      DONE   = 2'd3
   } state_t;

   localparam logic [TUBE_W-1:0]   TUBE_INIT = TUBE_W'(TUBE_RESET);
   localparam logic [TUBE_W-1:0]   TUBE_MAX  = '1;
   localparam logic [AMOUNT_W-1:0] VAL_N     = AMOUNT_W'(5);
   localparam logic [AMOUNT_W-1:0] VAL_D     = AMOUNT_W'(10);
   localparam logic [AMOUNT_W-1:0] VAL_Q     = AMOUNT_W'(25);

   function automatic logic [AMOUNT_W-1:0] coin_value(input coins_t c);
      case (c)
         COIN_NICKEL:  coin_value = VAL_N;
         COIN_DIME:    coin_value = VAL_D;
         COIN_QUARTER: coin_value = VAL_Q;
         default:      coin_value = '0;
      endcase
   endfunction

   state_t              state_q, state_d;
   logic [AMOUNT_W-1:0] remaining_q, remaining_d;
   coins_t              coin_type_q, coin_type_d;
   coins_t              pick;
   logic                handshake;

   // Tube stock, indexed by coins_t code (1 = nickel .. 3 = quarter).
   logic [TUBE_W-1:0]   tube_cnt [1:3];
   logic [3:1]          dep_hit;
   logic [3:1]          ej_hit;

   assign handshake = (state_q == EJECT) && bus.coin_ready;

   // ---------------------------------------------------------------------------
   // Greedy coin choice. It is based only on the registered tube counts, so a
   // deposit landing in this same cycle affects the following SELECT.
   // ---------------------------------------------------------------------------
   always_comb begin
      pick = COIN_NONE;
      if (remaining_q >= VAL_Q && tube_cnt[3] != '0)
         pick = COIN_QUARTER;
      else if (remaining_q >= VAL_D && tube_cnt[2] != '0)
         pick = COIN_DIME;
      else if (remaining_q >= VAL_N && tube_cnt[1] != '0)
         pick = COIN_NICKEL;
   end

   // ---------------------------------------------------------------------------
   // FSM: next state and next data.
   // ---------------------------------------------------------------------------
   // NOTE: every variable written here gets a default first. Otherwise a path
   // that skips an assignment would infer a latch.
   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      coin_type_d = coin_type_q;
      case (state_q)
         IDLE: begin
            if (bus.change_req) begin
               remaining_d = bus.change_amount;
               state_d     = SELECT;
            end
         end
         SELECT: begin
            if (pick != COIN_NONE) begin
               coin_type_d = pick;
               state_d     = EJECT;
            end else begin
               state_d     = DONE;
            end
         end
         EJECT: begin
            // coin_type_q is only chosen when its value is <= remaining_q,
            // so this subtraction cannot wrap.
            if (bus.coin_ready) begin
               remaining_d = remaining_q - coin_value(coin_type_q);
               state_d     = SELECT;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state is written with non-blocking assignments. All
   // registers then update together from the values present before the edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         remaining_q <= '0;
         coin_type_q <= COIN_NONE;
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         coin_type_q <= coin_type_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Tube bookkeeping.
   // A deposit and an ejection on the same tube cancel out. This still holds
   // when the tube is full: the saturating increment is not allowed to hide
   // the decrement.
   // ---------------------------------------------------------------------------
   always_comb begin
      dep_hit = '0;
      ej_hit  = '0;
      for (int i = 1; i <= 3; i++) begin
         dep_hit[i] = bus.deposit_valid && (bus.deposit_coin == 2'(i));
         ej_hit[i]  = handshake && (coin_type_q == coins_t'(i));
      end
   end

   // NOTE: this small array is reset on purpose. The tubes must reload to a
   // known stock on reset. Large storage arrays normally are not reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 1; i <= 3; i++) tube_cnt[i] <= TUBE_INIT;
      end else begin
         for (int i = 1; i <= 3; i++) begin
            if (dep_hit[i] && !ej_hit[i]) begin
               if (tube_cnt[i] != TUBE_MAX) tube_cnt[i] <= tube_cnt[i] + 1'b1;
            end else if (ej_hit[i] && !dep_hit[i]) begin
               tube_cnt[i] <= tube_cnt[i] - 1'b1;
            end
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs. The strobes are decoded from the state register. Because of
   // this, coin_valid drops as soon as the asynchronous reset clears the
   // state.
   // ---------------------------------------------------------------------------
   assign bus.change_busy  = (state_q != IDLE);
   assign bus.coin_valid   = (state_q == EJECT);
   assign bus.coin_type    = coin_type_q;
   assign bus.change_done  = (state_q == DONE);
   assign bus.change_short = (state_q == DONE) && (remaining_q != '0);
   assign bus.remaining    = remaining_q;
   assign bus.nickel_cnt   = tube_cnt[1];
   assign bus.dime_cnt     = tube_cnt[2];
   assign bus.quarter_cnt  = tube_cnt[3];

endmodule

// File: tb/tb_vm2002_change_dispenser.sv
// -----------------------------------------------------------------------------
// tb_vm2002_change_dispenser
//
// Directed test of the change dispenser. It covers:
//   - greedy payout and latency
//   - shortfall handling
//   - back-pressure on the ejector handshake
//   - tube saturation, and a deposit colliding with an ejection on one tube
//   - reset in the middle of an ejection
// All stimulus is driven, and all outputs sampled, 1 time unit after the
// rising clock edge.
// -----------------------------------------------------------------------------
module tb_vm2002_change_dispenser;

   localparam logic [1:0] NICKEL  = 2'd1;
   localparam logic [1:0] DIME    = 2'd2;
   localparam logic [1:0] QUARTER = 2'd3;

   logic clk;
   logic rst_n;

   vm2002_change_dispenser_if #(.AMOUNT_W(8), .TUBE_W(4)) bus ();

   vm2002_change_dispenser #(
      .AMOUNT_W   (8),
      .TUBE_W     (4),
      .TUBE_RESET (8)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Results of the last do_change() call. Coins are packed two bits per coin
   // into seq, with the first coin in the most significant position.
   logic [31:0] seq;
   int          ncoins;
   bit          got_done;
   logic        got_short;
   logic [7:0]  got_rem;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      rst_n             = 1'b0;
      bus.change_req    = 1'b0;
      bus.change_amount = '0;
      bus.deposit_valid = 1'b0;
      bus.deposit_coin  = '0;
      repeat (2) step();
      check("rst_busy",    bus.change_busy,  0);
      check("rst_valid",   bus.coin_valid,   0);
      check("rst_type",    bus.coin_type,    0);
      check("rst_done",    {bus.change_done, bus.change_short}, 0);
      check("rst_rem",     bus.remaining,    0);
      check("rst_tubes",   {bus.nickel_cnt, bus.dime_cnt, bus.quarter_cnt}, 12'h888);
      rst_n = 1'b1;
      step();
   endtask

   task automatic deposit(input logic [1:0] c);
      bus.deposit_valid = 1'b1;
      bus.deposit_coin  = c;
      step();
      bus.deposit_valid = 1'b0;
      bus.deposit_coin  = '0;
   endtask

   // Issue one request and record every handshaken coin until change_done
   // appears. The wait is bounded at 200 cycles.
   task automatic do_change(input logic [7:0] amt);
      seq      = '0;
      ncoins   = 0;
      got_done = 1'b0;
      bus.change_req    = 1'b1;
      bus.change_amount = amt;
      step();
      bus.change_req = 1'b0;
      for (int i = 0; i < 200 && !got_done; i++) begin
         if (bus.change_done) begin
            got_done  = 1'b1;
            got_short = bus.change_short;
            got_rem   = bus.remaining;
         end else begin
            if (bus.coin_valid && bus.coin_ready) begin
               seq = {seq[29:0], bus.coin_type};
               ncoins++;
            end
            step();
         end
      end
      check("done_seen", {31'd0, got_done}, 1);
      step();
      check("idle_after_done", {bus.change_busy, bus.change_done}, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit flag;
      rst_n          = 1'b0;
      bus.coin_ready = 1'b1;
      apply_reset();

      // ---- 40c from full tubes: Q, D, N ----
      do_change(8'd40);
      check("t1_ncoins", ncoins, 3);
      check("t1_seq",    seq, 32'h39);
      check("t1_short",  got_short, 0);
      check("t1_rem",    got_rem, 0);
      check("t1_tubes",  {bus.nickel_cnt, bus.dime_cnt, bus.quarter_cnt}, 12'h777);

      // ---- zero amount: no coins, not short ----
      do_change(8'd0);
      check("t0_ncoins", ncoins, 0);
      check("t0_short",  got_short, 0);

      // ---- 7c: one nickel, 2c residue ----
      do_change(8'd7);
      check("t7_seq",    seq, 32'h1);
      check("t7_short",  got_short, 1);
      check("t7_rem",    got_rem, 2);
      check("t7_nickel", bus.nickel_cnt, 6);

      // ---- drain quarters, then 30c paid with dimes ----
      apply_reset();
      do_change(8'd200);
      check("t2a_ncoins",  ncoins, 8);
      check("t2a_seq",     seq, 32'hFFFF);
      check("t2a_quarter", bus.quarter_cnt, 0);
      do_change(8'd30);
      check("t2_seq",      seq, 32'h2A);
      check("t2_short",    got_short, 0);
      check("t2_dime",     bus.dime_cnt, 5);

      // ---- set up nickel=0, dime=1, quarter=0 and ask for 15c ----
      do_change(8'd50);
      check("t3a_seq",  seq, 32'h2AA);
      check("t3a_dime", bus.dime_cnt, 0);
      do_change(8'd40);
      check("t3b_seq",    seq, 32'h5555);
      check("t3b_nickel", bus.nickel_cnt, 0);
      deposit(DIME);
      check("t3_dep_dime", bus.dime_cnt, 1);
      do_change(8'd15);
      check("t3_seq",      seq, 32'h2);
      check("t3_short",    got_short, 1);
      check("t3_rem",      got_rem, 5);
      check("t3_rem_hold", bus.remaining, 5);
      check("t3_dime",     bus.dime_cnt, 0);

      // ---- back-pressure: 25c with coin_ready low for 5 cycles ----
      apply_reset();
      bus.coin_ready    = 1'b0;
      bus.change_req    = 1'b1;
      bus.change_amount = 8'd25;
      step();
      bus.change_req = 1'b0;
      check("t4_select", {bus.change_busy, bus.coin_valid}, 2'b10);
      step();
      check("t4_first_valid", {bus.coin_valid, bus.coin_type}, {1'b1, QUARTER});
      for (int i = 0; i < 4; i++) begin
         step();
         check("t4_hold", {bus.coin_valid, bus.coin_type}, {1'b1, QUARTER});
      end
      check("t4_q_before", bus.quarter_cnt, 8);
      bus.coin_ready = 1'b1;
      step();
      check("t4_after_hs", {bus.coin_valid, bus.quarter_cnt, bus.remaining}, {1'b0, 4'd7, 8'd0});
      step();
      check("t4_done", {bus.change_done, bus.change_short}, 2'b10);
      step();
      check("t4_idle", bus.change_busy, 0);

      // ---- saturation and deposit of code 0 ----
      apply_reset();
      repeat (7) deposit(NICKEL);
      check("t5_nickel15", bus.nickel_cnt, 15);
      deposit(NICKEL);
      check("t5_nickel_sat", bus.nickel_cnt, 15);
      deposit(2'd0);
      check("t5_code0", {bus.nickel_cnt, bus.dime_cnt, bus.quarter_cnt}, 12'hF88);

      // ---- dime deposit colliding with a dime ejection at saturation ----
      repeat (7) deposit(DIME);
      check("t6_dime15", bus.dime_cnt, 15);
      bus.coin_ready    = 1'b0;
      bus.change_req    = 1'b1;
      bus.change_amount = 8'd10;
      step();
      bus.change_req = 1'b0;
      step();
      check("t6_eject", {bus.coin_valid, bus.coin_type}, {1'b1, DIME});
      bus.coin_ready    = 1'b1;
      bus.deposit_valid = 1'b1;
      bus.deposit_coin  = DIME;
      step();
      bus.deposit_valid = 1'b0;
      bus.deposit_coin  = '0;
      check("t6_collide", {bus.coin_valid, bus.dime_cnt, bus.remaining}, {1'b0, 4'd15, 8'd0});
      step();
      check("t6_done", {bus.change_done, bus.change_short}, 2'b10);
      step();

      // ---- reset in the middle of an ejection ----
      apply_reset();
      bus.coin_ready    = 1'b1;
      bus.change_req    = 1'b1;
      bus.change_amount = 8'd50;
      step();
      bus.change_req = 1'b0;
      step();   // EJECT, first quarter offered
      step();   // handshake taken, back in SELECT
      bus.coin_ready = 1'b0;
      step();   // EJECT, second quarter waiting
      check("t7_mid", {bus.coin_valid, bus.quarter_cnt}, {1'b1, 4'd7});
      rst_n = 1'b0;
      #1;
      check("t7_rst_valid", {bus.coin_valid, bus.change_busy}, 0);
      check("t7_rst_tubes", {bus.nickel_cnt, bus.dime_cnt, bus.quarter_cnt}, 12'h888);
      check("t7_rst_rem",   bus.remaining, 0);
      step();
      rst_n = 1'b1;
      flag  = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         flag = flag | bus.change_done | bus.change_busy | bus.coin_valid;
      end
      check("t7_no_done", {31'd0, flag}, 0);
      bus.coin_ready = 1'b1;
      do_change(8'd40);
      check("t7_rerun_seq",   seq, 32'h39);
      check("t7_rerun_short", got_short, 0);
      check("t7_rerun_tubes", {bus.nickel_cnt, bus.dime_cnt, bus.quarter_cnt}, 12'h777);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
